mc_control_fsm: RTL
===================

# mc_control_fsm

Multi-cycle main controller for the RV32I core. Sequences one instruction at a time through fetch, decode, execute, memory and writeback. Drives the shared datapath: immediate generator select, ALU operand muxes, ALU operation, memory strobes and register/PC/IR write enables. Sits beside the datapath in the core top and takes only the opcode fields and one branch-condition flag back from it.

## Interface
**Parameters**
- IMMSRC_WIDTH, 3, width of the immediate-format select.
- ALUCTRL_WIDTH, 4, width of the ALU operation code.

**Ports**
- clk, input, 1, core clock.
- rst_n, input, 1, asynchronous active-low reset.
- opcode, input, 7, instr[6:0] from the instruction register.
- funct3, input, 3, instr[14:12].
- funct7_5, input, 1, instr[30].
- branch_cond, input, 1, comparator result for the current branch's funct3. High means taken.
- mem_ready, input, 1, memory access completes this cycle. Used only with WAIT_STATE_EN.
- mem_req, output, 1, memory access request.
- mem_we, output, 1, memory write strobe.
- adr_src, output, 1, memory address source: 0 = PC, 1 = ALU result register.
- ir_we, output, 1, instruction register and old-PC register write enable.
- pc_we, output, 1, PC write enable.
- reg_we, output, 1, register file write enable.
- imm_src, output, IMMSRC_WIDTH, immediate format select.
- alu_src_a, output, 2, ALU operand A: 00 = PC, 01 = old PC, 10 = rs1.
- alu_src_b, output, 2, ALU operand B: 00 = rs2, 01 = immediate, 10 = constant 4.
- alu_ctrl, output, ALUCTRL_WIDTH, ALU operation.
- result_src, output, 2, result mux: 00 = ALU result register, 01 = memory data register, 10 = ALU output direct, 11 = immediate.
- illegal, output, 1, sticky unsupported-opcode flag.

## Operation
- Moore FSM. All outputs are decoded from the state register plus the IR fields.
- While rst_n = 0, the state is FETCH and every strobe (mem_req, mem_we, ir_we, pc_we, reg_we) is forced to 0. illegal is cleared.
- **FETCH**
  - Asserts mem_req, adr_src = 0, ir_we, pc_we, alu_src_a = 00, alu_src_b = 10, alu_ctrl = ADD, result_src = 10.
  - Goes to DECODE.
- **DECODE**
  - Computes old PC + imm(B) into the ALU result register for branch target reuse: alu_src_a = 01, alu_src_b = 01, imm_src = 010.
  - Next state by opcode: LOAD/STORE → MEMADR; OP → EXECR; OP-IMM → EXECI; BRANCH → BRANCH; JAL → JAL; JALR → JALR; LUI → LUI; AUIPC → AUIPC.
  - Any other opcode → TRAP.
- **MEMADR**: rs1 + imm, with imm_src = 000 for loads and 001 for stores. Goes to MEMREAD (load) or MEMWRITE (store).
- **MEMREAD**: mem_req, adr_src = 1. Goes to MEMWB.
- **MEMWB**: reg_we, result_src = 01. Goes to FETCH.
- **MEMWRITE**: mem_req, mem_we, adr_src = 1. Goes to FETCH.
- **EXECR**: rs1 op rs2. alu_ctrl comes from funct3/funct7_5. Goes to ALUWB.
- **EXECI**: rs1 op imm. Goes to ALUWB.
  - imm_src = 101 (shamt) for funct3 001 and 101.
  - imm_src = 000 otherwise.
  - funct7_5 selects SRA only for funct3 101; otherwise it is ignored (no SUBI).
- **ALUWB**: reg_we, result_src = 00. Goes to FETCH.
- **BRANCH**
  - Comparison: rs1 vs rs2 with alu_ctrl = SUB.
  - pc_we = branch_cond, result_src = 00, so the target is taken from the DECODE result.
  - Goes to FETCH.
- **JAL**: old PC + 4 computed into the result register; pc_we with target old PC + imm(J), imm_src = 100, result_src = 10. Goes to ALUWB.
- **JALR**: same as JAL, with target rs1 + imm(I). Goes to ALUWB.
- **LUI**: reg_we, imm_src = 011, result_src = 11. Goes to FETCH.
- **AUIPC**: old PC + imm(U), imm_src = 011. Goes to ALUWB.
- **TRAP**: illegal = 1. All strobes stay at 0. Remains in TRAP until reset.
- In states that do not use the immediate, imm_src = 000.

## Timing
- Latency from FETCH entry to the next FETCH entry, with zero wait states:
  - 3 cycles: branch, LUI.
  - 4 cycles: R-type, I-type, store, JAL, JALR, AUIPC.
  - 5 cycles: load.
- State register updates on the rising edge of clk. Reset is asynchronous on assertion and synchronous on release, with the first FETCH in the first clock edge after rst_n rises.
- Reset asserted mid-instruction aborts the instruction at once. No write strobe is asserted in that cycle or after.

## Configuration
- **WAIT_STATE_EN defined**: FETCH, MEMREAD and MEMWRITE hold while mem_ready = 0.
  - mem_req is held high.
  - ir_we, pc_we and mem_we are asserted only in the cycle mem_ready = 1, and the state advances on that cycle.
- **WAIT_STATE_EN undefined**: mem_ready is ignored and every memory state lasts exactly one cycle.

## Structure
- Shared package holds:
  - the state enum;
  - the opcode constants;
  - the imm_src encodings: 000 I, 001 S, 010 B, 011 U, 100 J, 101 shamt, 110 I-unsigned (defined, not issued);
  - the alu_ctrl encodings;
  - the alu_src_a/b and result_src encodings.
- One combinational sub-module, alu_decoder, maps state class, funct3 and funct7_5 to alu_ctrl.

## Test plan
- **R-type**: ADD (0x00B50533) in IR → states FETCH, DECODE, EXECR, ALUWB; alu_ctrl = ADD; reg_we high only in cycle 4.
- **Load**: LW (0x0002A303) → 5 cycles; MEMADR imm_src = 000; MEMREAD mem_req = 1, adr_src = 1; MEMWB reg_we = 1, result_src = 01.
- **Branch**: BEQ with branch_cond = 1 → pc_we in cycle 3. With branch_cond = 0 → pc_we in cycle 3 is 0; the only pc_we in the instruction is in FETCH.
- **Shift immediate**: SRAI (funct3 101, funct7_5 = 1) → EXECI imm_src = 101, alu_ctrl = SRA. SLLI → SLL.
- **Illegal and reset**: opcode 0x7F → TRAP, illegal = 1 held for 10 cycles. rst_n pulse → illegal = 0, state FETCH.
- **Wait states (WAIT_STATE_EN)**: mem_ready low for 3 cycles in FETCH → mem_req high for 4 cycles; ir_we/pc_we are one-cycle pulses on cycle 4. Reset asserted during the wait → no strobes.

Source files
------------

// File: rtl/mc_control_fsm_pkg.sv
// Shared types and encodings for the multi-cycle RV32I main controller.
// Covers FSM states, opcodes, immediate formats, ALU ops and datapath mux selects.
package mc_control_fsm_pkg;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAdr,
        StMemRead,
        StMemWb,
        StMemWrite,
        StExecR,
        StExecI,
        StAluWb,
        StBranch,
        StJal,
        StJalr,
        StLui,
        StAuipc,
        StTrap
    } state_e;

    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;

    // ImmIu is reserved for a future unsigned-compare immediate and is never issued.
    typedef enum logic [2:0] {
        ImmI     = 3'b000,
        ImmS     = 3'b001,
        ImmB     = 3'b010,
        ImmU     = 3'b011,
        ImmJ     = 3'b100,
        ImmShamt = 3'b101,
        ImmIu    = 3'b110
    } imm_src_e;

    typedef enum logic [3:0] {
        AluAdd  = 4'd0,
        AluSub  = 4'd1,
        AluSll  = 4'd2,
        AluSlt  = 4'd3,
        AluSltu = 4'd4,
        AluXor  = 4'd5,
        AluSrl  = 4'd6,
        AluSra  = 4'd7,
        AluOr   = 4'd8,
        AluAnd  = 4'd9
    } alu_op_e;

    // Which rule the ALU decoder applies: fixed ADD/SUB, or funct-driven for R/I formats.
    typedef enum logic [1:0] {
        AluClsAdd,
        AluClsSub,
        AluClsR,
        AluClsI
    } alu_class_e;

    typedef enum logic [1:0] {
        SrcAPc    = 2'b00,
        SrcAOldPc = 2'b01,
        SrcARs1   = 2'b10
    } src_a_e;

    typedef enum logic [1:0] {
        SrcBRs2  = 2'b00,
        SrcBImm  = 2'b01,
        SrcBFour = 2'b10
    } src_b_e;

    typedef enum logic [1:0] {
        ResAluReg    = 2'b00,
        ResMemData   = 2'b01,
        ResAluDirect = 2'b10,
        ResImm       = 2'b11
    } result_src_e;

    function automatic state_e decode_next(input logic [6:0] opc);
        case (opc)
            OpcLoad, OpcStore: decode_next = StMemAdr;
            OpcOp:             decode_next = StExecR;
            OpcOpImm:          decode_next = StExecI;
            OpcBranch:         decode_next = StBranch;
            OpcJal:            decode_next = StJal;
            OpcJalr:           decode_next = StJalr;
            OpcLui:            decode_next = StLui;
            OpcAuipc:          decode_next = StAuipc;
            default:           decode_next = StTrap;
        endcase
    endfunction

endpackage

// File: rtl/mc_control_fsm_alu_decoder.sv
// Combinational ALU operation decoder: maps the state's ALU class plus funct3/funct7_5
// to an ALU operation code.
module mc_control_fsm_alu_decoder
    import mc_control_fsm_pkg::*;
(
    input  alu_class_e  alu_class,
    input  logic [2:0]  funct3,
    input  logic        funct7_5,
    output alu_op_e     alu_ctrl
);

    always_comb begin
        alu_ctrl = AluAdd;
        unique case (alu_class)
            AluClsAdd: alu_ctrl = AluAdd;
            AluClsSub: alu_ctrl = AluSub;
            default: begin
                unique case (funct3)
                    // There is no SUBI, so funct7_5 only means SUB for register operands.
                    3'b000: alu_ctrl = (alu_class == AluClsR && funct7_5) ? AluSub : AluAdd;
                    3'b001: alu_ctrl = AluSll;
                    3'b010: alu_ctrl = AluSlt;
                    3'b011: alu_ctrl = AluSltu;
                    3'b100: alu_ctrl = AluXor;
                    3'b101: alu_ctrl = funct7_5 ? AluSra : AluSrl;
                    3'b110: alu_ctrl = AluOr;
                    3'b111: alu_ctrl = AluAnd;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle RV32I main controller (Moore FSM driving the shared datapath).
// Define WAIT_STATE_EN to make FETCH/MEMREAD/MEMWRITE stall until mem_ready.
module mc_control_fsm
    import mc_control_fsm_pkg::*;
#(
    parameter int IMMSRC_WIDTH  = 3,
    parameter int ALUCTRL_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [6:0]               opcode,
    input  logic [2:0]               funct3,
    input  logic                     funct7_5,
    input  logic                     branch_cond,
    input  logic                     mem_ready,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic                     adr_src,
    output logic                     ir_we,
    output logic                     pc_we,
    output logic                     reg_we,
    output logic [IMMSRC_WIDTH-1:0]  imm_src,
    output logic [1:0]               alu_src_a,
    output logic [1:0]               alu_src_b,
    output logic [ALUCTRL_WIDTH-1:0] alu_ctrl,
    output logic [1:0]               result_src,
    output logic                     illegal
);

    state_e      state;
    logic        illegal_q;
    logic        mem_done;

    alu_class_e  alu_class;
    alu_op_e     alu_op;
    imm_src_e    imm_sel;
    src_a_e      src_a;
    src_b_e      src_b;
    result_src_e res_sel;
    logic        mem_req_c, mem_we_c, ir_we_c, pc_we_c, reg_we_c, adr_c;

`ifdef WAIT_STATE_EN
    assign mem_done = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign mem_done = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StFetch;
            illegal_q <= 1'b0;
        end else begin
            unique case (state)
                StFetch:    if (mem_done) state <= StDecode;
                StDecode: begin
                    state     <= decode_next(opcode);
                    illegal_q <= illegal_q | (decode_next(opcode) == StTrap);
                end
                StMemAdr:   state <= (opcode == OpcStore) ? StMemWrite : StMemRead;
                StMemRead:  if (mem_done) state <= StMemWb;
                StMemWrite: if (mem_done) state <= StFetch;
                StExecR, StExecI, StJal, StJalr, StAuipc: state <= StAluWb;
                StMemWb, StAluWb, StBranch, StLui:        state <= StFetch;
                StTrap:     state <= StTrap;
                default:    state <= StFetch;
            endcase
        end
    end

    always_comb begin
        alu_class = AluClsAdd;
        imm_sel   = ImmI;
        src_a     = SrcAPc;
        src_b     = SrcBRs2;
        res_sel   = ResAluReg;
        mem_req_c = 1'b0;
        mem_we_c  = 1'b0;
        ir_we_c   = 1'b0;
        pc_we_c   = 1'b0;
        reg_we_c  = 1'b0;
        adr_c     = 1'b0;
        unique case (state)
            StFetch: begin
                mem_req_c = 1'b1;
                ir_we_c   = mem_done;
                pc_we_c   = mem_done;
                src_b     = SrcBFour;
                res_sel   = ResAluDirect;
            end
            // Branch target is precomputed here and reused from the result register.
            StDecode: begin
                src_a   = SrcAOldPc;
                src_b   = SrcBImm;
                imm_sel = ImmB;
            end
            StMemAdr: begin
                src_a   = SrcARs1;
                src_b   = SrcBImm;
                imm_sel = (opcode == OpcStore) ? ImmS : ImmI;
            end
            StMemRead: begin
                mem_req_c = 1'b1;
                adr_c     = 1'b1;
            end
            StMemWb: begin
                reg_we_c = 1'b1;
                res_sel  = ResMemData;
            end
            StMemWrite: begin
                mem_req_c = 1'b1;
                mem_we_c  = mem_done;
                adr_c     = 1'b1;
            end
            StExecR: begin
                src_a     = SrcARs1;
                src_b     = SrcBRs2;
                alu_class = AluClsR;
            end
            StExecI: begin
                src_a     = SrcARs1;
                src_b     = SrcBImm;
                alu_class = AluClsI;
                imm_sel   = (funct3[1:0] == 2'b01) ? ImmShamt : ImmI;
            end
            StAluWb: reg_we_c = 1'b1;
            StBranch: begin
                src_a     = SrcARs1;
                src_b     = SrcBRs2;
                alu_class = AluClsSub;
                pc_we_c   = branch_cond;
            end
            StJal, StJalr: begin
                src_a   = SrcAOldPc;
                src_b   = SrcBFour;
                pc_we_c = 1'b1;
                imm_sel = (state == StJal) ? ImmJ : ImmI;
                res_sel = ResAluDirect;
            end
            StLui: begin
                reg_we_c = 1'b1;
                imm_sel  = ImmU;
                res_sel  = ResImm;
            end
            StAuipc: begin
                src_a   = SrcAOldPc;
                src_b   = SrcBImm;
                imm_sel = ImmU;
            end
            StTrap: ;
            default: ;
        endcase
    end

    mc_control_fsm_alu_decoder u_alu_decoder (
        .alu_class (alu_class),
        .funct3    (funct3),
        .funct7_5  (funct7_5),
        .alu_ctrl  (alu_op)
    );

    // Strobes are gated by rst_n so an in-flight instruction is killed the moment reset hits.
    assign mem_req    = rst_n & mem_req_c;
    assign mem_we     = rst_n & mem_we_c;
    assign ir_we      = rst_n & ir_we_c;
    assign pc_we      = rst_n & pc_we_c;
    assign reg_we     = rst_n & reg_we_c;
    assign adr_src    = adr_c;
    assign imm_src    = IMMSRC_WIDTH'(imm_sel);
    assign alu_src_a  = src_a;
    assign alu_src_b  = src_b;
    assign alu_ctrl   = ALUCTRL_WIDTH'(alu_op);
    assign result_src = res_sel;
    assign illegal    = illegal_q;

endmodule
